// File: rtl/imu_sample_scheduler_pkg.sv
// Shared definitions for the IMU sample scheduler: FSM state encoding and default widths.
package imu_sample_scheduler_pkg;

  localparam int DATA_W_DEF   = 10;
  localparam int SAMPLE_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_LATCH     = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

endpackage

// File: rtl/imu_sample_scheduler_sched_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module imu_sample_scheduler_sched_timer #(
  parameter int LOAD_VAL = 1
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int W = (LOAD_VAL < 1) ? 1 : $clog2(LOAD_VAL + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cnt <= W'(LOAD_VAL);
    end else if (load) begin
      cnt <= W'(LOAD_VAL);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/imu_sample_scheduler.sv
// Periodic IMU read sequencer: tick -> READ_START -> wait DATA_VALID (timeout/retry) -> latch sample.
//   state        | meaning
//   ST_IDLE      | scheduling disabled
//   ST_WAIT_TICK | waiting for the sample period tick
//   ST_START     | READ_START pulse, timeout timer loaded
//   ST_WAIT_DATA | waiting for DATA_VALID rise or timeout
//   ST_LATCH     | capture all three axes, pulse SAMPLE_READY
//   ST_FAULT     | retries exhausted, set sticky FAULT
module imu_sample_scheduler
  import imu_sample_scheduler_pkg::*;
#(
  parameter int PERIOD_CYCLES  = 500000,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRIES    = 2,
  parameter int DATA_W         = DATA_W_DEF
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic                    ENABLE,
  input  logic                    FAULT_CLR,
  input  logic                    DATA_VALID,
  input  logic [DATA_W-1:0]       AccelX,
  input  logic [DATA_W-1:0]       AccelY,
  input  logic [DATA_W-1:0]       AccelZ,
  output logic                    READ_START,
  output logic [DATA_W-1:0]       SampleX,
  output logic [DATA_W-1:0]       SampleY,
  output logic [DATA_W-1:0]       SampleZ,
  output logic                    SAMPLE_READY,
  output logic [SAMPLE_CNT_W-1:0] SAMPLE_CNT,
  output logic                    FAULT,
  output logic                    OVERRUN
);

  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_t state, state_nxt;
  logic [RETRY_W-1:0] retry;
  logic [SAMPLE_CNT_W-1:0] sample_cnt_q;
  logic dv_q, rise, period_tc, tick, tmo_tc;
  logic tmo_load, retry_inc, retry_clr, do_latch, do_fault;

  assign rise = DATA_VALID & ~dv_q;
  assign tick = ENABLE & period_tc;

  // Reloads on every tick and is held at full count while disabled.
  imu_sample_scheduler_sched_timer #(.LOAD_VAL(PERIOD_CYCLES - 1)) u_period (
    .clk_sys (CLOCK_50),
    .rst     (RESET),
    .load    (~ENABLE | tick),
    .en      (ENABLE),
    .tc      (period_tc)
  );

  imu_sample_scheduler_sched_timer #(.LOAD_VAL(TIMEOUT_CYCLES - 1)) u_timeout (
    .clk_sys (CLOCK_50),
    .rst     (RESET),
    .load    (tmo_load),
    .en      (state == ST_WAIT_DATA),
    .tc      (tmo_tc)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      dv_q  <= 1'b0;
      retry <= '0;
    end else begin
      state <= state_nxt;
      dv_q  <= DATA_VALID;
      if (retry_clr) retry <= '0;
      else if (retry_inc) retry <= retry + RETRY_W'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    READ_START = 1'b0;
    tmo_load   = 1'b0;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
    do_latch   = 1'b0;
    do_fault   = 1'b0;
    if (!ENABLE) begin
      state_nxt = ST_IDLE;
      retry_clr = 1'b1;
    end else begin
      case (state)
        ST_IDLE:      state_nxt = ST_WAIT_TICK;
        ST_WAIT_TICK: if (tick) state_nxt = ST_START;
        ST_START: begin
          READ_START = 1'b1;
          tmo_load   = 1'b1;
          state_nxt  = ST_WAIT_DATA;
        end
        ST_WAIT_DATA: begin
          // A rise in the same cycle as expiry still counts as a good read.
          if (rise) begin
            state_nxt = ST_LATCH;
          end else if (tmo_tc) begin
            if (retry < RETRY_MAX) begin
              retry_inc = 1'b1;
              state_nxt = ST_START;
            end else begin
              state_nxt = ST_FAULT;
            end
          end
        end
        ST_LATCH: begin
          do_latch  = 1'b1;
          retry_clr = 1'b1;
          state_nxt = ST_WAIT_TICK;
        end
        ST_FAULT: begin
          do_fault  = 1'b1;
          retry_clr = 1'b1;
          state_nxt = ST_WAIT_TICK;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // All three axes move together, only on the LATCH cycle.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      SampleX      <= '0;
      SampleY      <= '0;
      SampleZ      <= '0;
      SAMPLE_READY <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      SAMPLE_READY <= do_latch;
      if (do_latch) begin
        SampleX      <= AccelX;
        SampleY      <= AccelY;
        SampleZ      <= AccelZ;
        sample_cnt_q <= sample_cnt_q + SAMPLE_CNT_W'(1);
      end
    end
  end

  assign SAMPLE_CNT = sample_cnt_q;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      FAULT   <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      if (do_fault) FAULT <= 1'b1;
      else if (FAULT_CLR) FAULT <= 1'b0;
      if (tick && (state != ST_WAIT_TICK)) OVERRUN <= 1'b1;
      else if (FAULT_CLR) OVERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imu_sample_scheduler.sv
// Directed bench for imu_sample_scheduler: period, latency, retry/fault, overrun, disable and wrap cases.
module tb_imu_sample_scheduler;

  localparam int P  = 100;
  localparam int T  = 20;
  localparam int T2 = 200;
  localparam int DW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en1, en2, fclr, dv;
  logic [DW-1:0] ax, ay, az;

  logic rs1, sr1, f1, o1;
  logic [DW-1:0] sx1, sy1, sz1;
  logic [15:0] cnt1;
  logic rs2, sr2, f2, o2;
  logic [DW-1:0] sx2, sy2, sz2;
  logic [15:0] cnt2;

  imu_sample_scheduler #(.PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T), .MAX_RETRIES(2), .DATA_W(DW)) dut (
    .CLOCK_50(clk), .RESET(rst), .ENABLE(en1), .FAULT_CLR(fclr), .DATA_VALID(dv),
    .AccelX(ax), .AccelY(ay), .AccelZ(az), .READ_START(rs1),
    .SampleX(sx1), .SampleY(sy1), .SampleZ(sz1), .SAMPLE_READY(sr1),
    .SAMPLE_CNT(cnt1), .FAULT(f1), .OVERRUN(o1)
  );

  imu_sample_scheduler #(.PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T2), .MAX_RETRIES(2), .DATA_W(DW)) dut2 (
    .CLOCK_50(clk), .RESET(rst), .ENABLE(en2), .FAULT_CLR(fclr), .DATA_VALID(dv),
    .AccelX(ax), .AccelY(ay), .AccelZ(az), .READ_START(rs2),
    .SampleX(sx2), .SampleY(sy2), .SampleZ(sz2), .SAMPLE_READY(sr2),
    .SAMPLE_CNT(cnt2), .FAULT(f2), .OVERRUN(o2)
  );

  typedef struct {
    int            dly;
    logic [DW-1:0] x, y, z;
    logic [15:0]   cnt;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int sr1_seen = 0;
  int rs1_seen = 0;

  always @(negedge clk) begin
    if (sr1) sr1_seen++;
    if (rs1) rs1_seen++;
  end

  task step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_rs(input int sel, input int budget, output int n);
    logic seen;
    n = 0;
    do begin
      step();
      n++;
      seen = (sel == 1) ? rs1 : rs2;
    end while (!seen && n < budget);
    check("read_start_seen", {31'd0, seen}, 32'd1);
  endtask

  // Called right after READ_START is observed; raises DATA_VALID dly clocks later.
  task automatic serve(input int dly, input logic [DW-1:0] x, y, z, input logic [15:0] exp_cnt);
    step();
    check("read_start_width", {31'd0, rs1}, 32'd0);
    for (int k = 1; k < dly; k++) step();
    dv = 1'b1; ax = x; ay = y; az = z;
    step();
    check("sample_ready_early", {31'd0, sr1}, 32'd0);
    check("no_retry_start", {31'd0, rs1}, 32'd0);
    step();
    check("sample_ready", {31'd0, sr1}, 32'd1);
    check("sample_x", {22'd0, sx1}, {22'd0, x});
    check("sample_y", {22'd0, sy1}, {22'd0, y});
    check("sample_z", {22'd0, sz1}, {22'd0, z});
    check("sample_cnt", {16'd0, cnt1}, {16'd0, exp_cnt});
    dv = 1'b0; ax = ~x; ay = ~y; az = ~z;
    step();
    check("sample_ready_width", {31'd0, sr1}, 32'd0);
    check("sample_hold", {22'd0, sx1}, {22'd0, x});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int n, a, b, c, s, last_rs, sr_before, rs_before, rs_extra;

    tbl[0] = '{5,  10'h155, 10'h0AA, 10'h3FF, 16'd1};
    tbl[1] = '{5,  10'h155, 10'h2AA, 10'h001, 16'd2};
    tbl[2] = '{5,  10'h155, 10'h000, 10'h3C3, 16'd3};
    tbl[3] = '{12, 10'h2A5, 10'h001, 10'h200, 16'd4};
    tbl[4] = '{20, 10'h0F0, 10'h30F, 10'h155, 16'd5};

    rst = 1'b1; en1 = 1'b0; en2 = 1'b0; fclr = 1'b0; dv = 1'b0;
    ax = '0; ay = '0; az = '0;
    step(); step(); step();
    check("rst_read_start", {31'd0, rs1}, 32'd0);
    check("rst_sample_ready", {31'd0, sr1}, 32'd0);
    check("rst_sample_x", {22'd0, sx1}, 32'd0);
    check("rst_cnt", {16'd0, cnt1}, 32'd0);
    check("rst_fault", {31'd0, f1}, 32'd0);
    check("rst_overrun", {31'd0, o1}, 32'd0);
    check("rst_overrun2", {31'd0, o2}, 32'd0);
    rst = 1'b0;
    step();

    // Good reads at several DATA_VALID delays, including rise coincident with timeout.
    en1 = 1'b1;
    last_rs = cyc;
    for (int i = 0; i < 5; i++) begin
      wait_rs(1, 150, n);
      check("read_start_period", cyc - last_rs, P);
      last_rs = cyc;
      serve(tbl[i].dly, tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].cnt);
    end

    // No DATA_VALID: three attempts 21 clocks apart, then FAULT.
    wait_rs(1, 150, n);
    check("read_start_period", cyc - last_rs, P);
    a = cyc;
    wait_rs(1, 30, n);
    check("retry1_spacing", cyc - a, T + 1);
    check("fault_during_retry", {31'd0, f1}, 32'd0);
    b = cyc;
    wait_rs(1, 30, n);
    check("retry2_spacing", cyc - b, T + 1);
    n = 0;
    do begin step(); n++; end while (!f1 && n < 40);
    check("fault_latency", n, T + 2);
    check("fault_set", {31'd0, f1}, 32'd1);
    wait_rs(1, 100, n);
    check("restart_after_fault", cyc - a, P);
    serve(5, 10'h11F, 10'h2E0, 10'h0C3, 16'd6);
    check("fault_sticky", {31'd0, f1}, 32'd1);
    fclr = 1'b1;
    step();
    fclr = 1'b0;
    check("fault_clr", {31'd0, f1}, 32'd0);
    check("no_overrun", {31'd0, o1}, 32'd0);

    // Fresh reset; first attempt times out, retry succeeds.
    rst = 1'b1;
    step(); step();
    check("rst2_cnt", {16'd0, cnt1}, 32'd0);
    check("rst2_sample_x", {22'd0, sx1}, 32'd0);
    rst = 1'b0;
    c = cyc;
    wait_rs(1, 150, n);
    check("read_start_after_reset", cyc - c, P);
    last_rs = cyc;
    sr_before = sr1_seen;
    a = cyc;
    wait_rs(1, 30, n);
    check("retry_spacing", cyc - a, T + 1);
    serve(5, 10'h1A5, 10'h05A, 10'h2DD, 16'd1);
    check("retry_ok_fault", {31'd0, f1}, 32'd0);
    check("retry_ok_one_ready", sr1_seen - sr_before, 1);

    // ENABLE dropped mid WAIT_DATA; late DATA_VALID must be discarded.
    wait_rs(1, 150, n);
    check("read_start_period", cyc - last_rs, P);
    step(); step(); step();
    en1 = 1'b0;
    sr_before = sr1_seen;
    rs_before = rs1_seen;
    for (int k = 0; k < 5; k++) step();
    dv = 1'b1; ax = 10'h3C3; ay = 10'h111; az = 10'h222;
    for (int k = 0; k < 5; k++) step();
    check("disabled_no_ready", sr1_seen - sr_before, 0);
    check("disabled_no_start", rs1_seen - rs_before, 0);
    check("disabled_sample_hold", {22'd0, sx1}, 32'h1A5);
    check("disabled_cnt_hold", {16'd0, cnt1}, 32'd1);
    dv = 1'b0;
    step();
    en1 = 1'b1;
    c = cyc;
    wait_rs(1, 150, n);
    check("reenable_first_start", cyc - c, P);

    // SAMPLE_CNT wrap with rise landing on the timeout cycle.
    force dut.sample_cnt_q = 16'hFFFF;
    #2;
    release dut.sample_cnt_q;
    serve(T, 10'h2B4, 10'h0E1, 10'h377, 16'h0000);
    en1 = 1'b0;

    // Overrun on the long-timeout instance: read still in flight when the next tick arrives.
    en2 = 1'b1;
    c = cyc;
    wait_rs(2, 150, n);
    check("dut2_first_start", cyc - c, P);
    s = cyc;
    rs_extra = 0;
    for (int k = 1; k <= 150; k++) begin
      step();
      if (rs2) rs_extra++;
      if (k == P - 1) check("overrun_before_tick", {31'd0, o2}, 32'd0);
      if (k == P) check("overrun_set", {31'd0, o2}, 32'd1);
    end
    dv = 1'b1; ax = 10'h099; ay = 10'h1EE; az = 10'h300;
    step(); step();
    check("dut2_sample_ready", {31'd0, sr2}, 32'd1);
    check("dut2_sample_x", {22'd0, sx2}, 32'h099);
    check("dut2_sample_y", {22'd0, sy2}, 32'h1EE);
    check("dut2_sample_z", {22'd0, sz2}, 32'h300);
    check("dut2_cnt", {16'd0, cnt2}, 32'd1);
    dv = 1'b0;
    wait_rs(2, 100, n);
    check("dut2_dropped_tick", cyc - s, 2 * P);
    check("dut2_no_extra_start", rs_extra, 0);
    check("dut2_fault", {31'd0, f2}, 32'd0);
    fclr = 1'b1;
    step();
    fclr = 1'b0;
    check("overrun_clr", {31'd0, o2}, 32'd0);
    en2 = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
